edge_bbox_tracker: RTL
======================

// Module: edge_bbox_tracker
// PURPOSE
//  Frame-level consumer of the Sobel edge stream (dout_valid/edge_data), placed directly downstream of the edge pipeline.
//  Tracks raster position, counts edge pixels and computes the bounding box of all edge pixels per frame.
//  Presents one result record per frame on a valid/ready interface to the control or readout logic.
// PARAMETERS
//  IMG_WIDTH   640  pixels per line
//  IMG_HEIGHT  480  lines per frame
//  EDGE_MIN    128  pixel counts as edge when edge_data >= EDGE_MIN (unsigned)
//  Derived widths: XW=$clog2(IMG_WIDTH), YW=$clog2(IMG_HEIGHT), CW=$clog2(IMG_WIDTH*IMG_HEIGHT+1)
// PORTS
//  clk          in   1   single clock domain
//  rst          in   1   synchronous reset, active-high
//  din_valid    in   1   edge pixel valid (from edge stage dout_valid)
//  edge_data    in   8   edge magnitude / binary edge pixel
//  sof          in   1   start of frame; qualified by din_valid; marks pixel (0,0)
//  res_valid    out  1   result record available
//  res_ready    in   1   consumer accepts record when res_valid & res_ready
//  x_min,x_max  out  XW  bbox columns (inclusive)
//  y_min,y_max  out  YW  bbox rows (inclusive)
//  edge_count   out  CW  number of edge pixels in frame
//  no_edge      out  1   frame contained zero edge pixels
//  res_overrun  out  1   record replaced an unconsumed previous record
//  sync_err     out  1   one-cycle pulse: sof arrived mid-frame
// BEHAVIOUR
//  - Reset: col=0,row=0, accumulators cleared, all outputs 0; sync_err 0; no record pending.
//  - Position: col/row advance only on din_valid; col wraps IMG_WIDTH-1 -> 0 with row+1; row wraps after last line.
//  - Gaps (din_valid=0) freeze all state; any number of idle cycles allowed, including mid-line.
//  - Accumulate per valid edge pixel: cnt+1; xmin=min, xmax=max, ymin=min, ymax=max; running min init all-ones, max init 0.
//  - End of frame: valid pixel at (IMG_WIDTH-1, IMG_HEIGHT-1). Its own contribution is included; record
//    loads into output regs on that edge, res_valid=1 the following cycle (latency 1 clk after last pixel).
//    Accumulators reset to init on the same edge; next valid pixel is (0,0) of the next frame.
//  - Empty frame: no_edge=1, edge_count=0, x_min=x_max=y_min=y_max=0.
//  - Output register: states EMPTY/FULL. EMPTY->FULL on frame end; FULL->EMPTY on res_valid&res_ready.
//    Outputs stable while FULL and not accepted.
//  - Frame end while FULL without handshake: newer record overwrites, res_overrun=1 in that record.
//  - Frame end same cycle as handshake: old record consumed, new loaded, res_overrun=0, res_valid stays 1.
//  - sof with din_valid: pixel forced to (0,0); if position was not (0,0) the partial frame is discarded,
//    accumulators restart with this pixel, sync_err pulses 1 cycle. sof without din_valid ignored.
//  - sof on the end-of-frame pixel position is impossible (position != (0,0) -> treated as mid-frame sof).
//  - rst mid-frame: partial frame and any pending record discarded; res_valid=0 next cycle.
//  - edge_count saturates at IMG_WIDTH*IMG_HEIGHT (cannot overflow by construction).
// CONFIGURATION
//  EDGE_BBOX_ROI_EN defined: adds inputs roi_x0,roi_x1 (XW) and roi_y0,roi_y1 (YW), sampled at each sof/frame start;
//    only edge pixels with roi_x0<=col<=roi_x1 and roi_y0<=row<=roi_y1 are accumulated; position tracking unchanged.
//    Empty ROI (x0>x1 or y0>y1) -> every record has no_edge=1.
//  Not defined: no ROI ports; whole frame accumulated.
// TESTING  (bench uses IMG_WIDTH=8, IMG_HEIGHT=4, EDGE_MIN=128)
//  1 Frame all 0 except 255 at (2,1),(5,3) -> 1 clk after last pixel res_valid=1, x 2..5, y 1..3, count=2, no_edge=0.
//  2 Frame all 0, res_ready=1 -> res_valid pulses 1 cycle, no_edge=1, count=0, bbox all 0.
//  3 Two frames, res_ready=0 throughout -> second record shown, res_overrun=1; raise res_ready -> res_valid=0 next clk.
//  4 sof at pixel 13 of frame (position (5,1)) -> sync_err pulse 1 clk; record reflects only the new 32 pixels.
//  5 Random din_valid gaps (50%) with edge=127 everywhere and 128 at (7,0) -> count=1, bbox x 7..7, y 0..0.
//  6 rst asserted at pixel 20 and with record pending -> res_valid=0 next clk; next full frame reports correctly.

Source files
------------

// File: rtl/edge_bbox_tracker.sv
// Frame-level edge statistics: raster position, edge pixel count and bounding box, one record per frame
// on a valid/ready output. Optional region-of-interest gating is enabled with EDGE_BBOX_ROI_EN.
module edge_bbox_tracker #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int EDGE_MIN   = 128,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT),
  localparam int CW = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  input  logic [7:0]    edge_data,
  input  logic          sof,
`ifdef EDGE_BBOX_ROI_EN
  input  logic [XW-1:0] roi_x0,
  input  logic [XW-1:0] roi_x1,
  input  logic [YW-1:0] roi_y0,
  input  logic [YW-1:0] roi_y1,
`endif
  output logic          res_valid,
  input  logic          res_ready,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic [CW-1:0] edge_count,
  output logic          no_edge,
  output logic          res_overrun,
  output logic          sync_err
);

  localparam logic [XW-1:0] COL_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [7:0]    EDGE_TH  = 8'(EDGE_MIN);

  typedef enum logic {S_EMPTY, S_FULL} ostate_t;
  ostate_t state, state_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CNT_MAX) ? v : v + CW'(1);
  endfunction

  logic [XW-1:0] col, col_nxt, pix_col;
  logic [YW-1:0] row, row_nxt, pix_row;
  logic [CW-1:0] acc_cnt, base_cnt, nxt_cnt;
  logic [XW-1:0] acc_xmin, acc_xmax, base_xmin, base_xmax, nxt_xmin, nxt_xmax;
  logic [YW-1:0] acc_ymin, acc_ymax, base_ymin, base_ymax, nxt_ymin, nxt_ymax;
  logic          frame_restart, mid_sof, roi_hit, hit, last_pix;

`ifdef EDGE_BBOX_ROI_EN
  logic [XW-1:0] roi_x0_q, roi_x1_q, rx0, rx1;
  logic [YW-1:0] roi_y0_q, roi_y1_q, ry0, ry1;
  logic          frame_first;

  // ROI is captured on the first pixel of each frame; that pixel already uses the live inputs
  always_comb begin
    frame_first = din_valid & (pix_col == '0) & (pix_row == '0);
    rx0 = frame_first ? roi_x0 : roi_x0_q;
    rx1 = frame_first ? roi_x1 : roi_x1_q;
    ry0 = frame_first ? roi_y0 : roi_y0_q;
    ry1 = frame_first ? roi_y1 : roi_y1_q;
    roi_hit = (pix_col >= rx0) & (pix_col <= rx1) & (pix_row >= ry0) & (pix_row <= ry1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      roi_x0_q <= '0;
      roi_x1_q <= '0;
      roi_y0_q <= '0;
      roi_y1_q <= '0;
    end else if (frame_first) begin
      roi_x0_q <= roi_x0;
      roi_x1_q <= roi_x1;
      roi_y0_q <= roi_y0;
      roi_y1_q <= roi_y1;
    end
  end
`else
  assign roi_hit = 1'b1;
`endif

  // A qualified sof forces this pixel to (0,0) and restarts the accumulators from their init values
  always_comb begin
    frame_restart = din_valid & sof;
    mid_sof   = frame_restart & ((col != '0) | (row != '0));
    pix_col   = frame_restart ? '0 : col;
    pix_row   = frame_restart ? '0 : row;
    base_cnt  = frame_restart ? '0 : acc_cnt;
    base_xmin = frame_restart ? '1 : acc_xmin;
    base_xmax = frame_restart ? '0 : acc_xmax;
    base_ymin = frame_restart ? '1 : acc_ymin;
    base_ymax = frame_restart ? '0 : acc_ymax;
    hit       = din_valid & (edge_data >= EDGE_TH) & roi_hit;
    nxt_cnt   = hit ? sat_inc(base_cnt) : base_cnt;
    nxt_xmin  = (hit && pix_col < base_xmin) ? pix_col : base_xmin;
    nxt_xmax  = (hit && pix_col > base_xmax) ? pix_col : base_xmax;
    nxt_ymin  = (hit && pix_row < base_ymin) ? pix_row : base_ymin;
    nxt_ymax  = (hit && pix_row > base_ymax) ? pix_row : base_ymax;
    last_pix  = din_valid & (pix_col == COL_LAST) & (pix_row == ROW_LAST);
    col_nxt   = (pix_col == COL_LAST) ? '0 : pix_col + XW'(1);
    row_nxt   = pix_row;
    if (pix_col == COL_LAST)
      row_nxt = (pix_row == ROW_LAST) ? '0 : pix_row + YW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      acc_cnt  <= '0;
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
    end else if (din_valid) begin
      col <= col_nxt;
      row <= row_nxt;
      if (last_pix) begin
        acc_cnt  <= '0;
        acc_xmin <= '1;
        acc_xmax <= '0;
        acc_ymin <= '1;
        acc_ymax <= '0;
      end else begin
        acc_cnt  <= nxt_cnt;
        acc_xmin <= nxt_xmin;
        acc_xmax <= nxt_xmax;
        acc_ymin <= nxt_ymin;
        acc_ymax <= nxt_ymax;
      end
    end
  end

  // Result register: a new record always loads; overrun flags an unconsumed predecessor
  always_ff @(posedge clk) begin
    if (rst) begin
      x_min       <= '0;
      x_max       <= '0;
      y_min       <= '0;
      y_max       <= '0;
      edge_count  <= '0;
      no_edge     <= 1'b0;
      res_overrun <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      sync_err <= mid_sof;
      if (last_pix) begin
        edge_count  <= nxt_cnt;
        no_edge     <= (nxt_cnt == '0);
        x_min       <= (nxt_cnt == '0) ? '0 : nxt_xmin;
        x_max       <= (nxt_cnt == '0) ? '0 : nxt_xmax;
        y_min       <= (nxt_cnt == '0) ? '0 : nxt_ymin;
        y_max       <= (nxt_cnt == '0) ? '0 : nxt_ymax;
        res_overrun <= (state == S_FULL) & ~res_ready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    res_valid = (state == S_FULL);
    case (state)
      S_EMPTY: if (last_pix) state_nxt = S_FULL;
      S_FULL:  if (!last_pix && res_ready) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
  end

endmodule
